// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Wait-counter width needed to count up to timeout-1.
  function automatic int wait_cnt_w(input int timeout);
    return $clog2(timeout);
  endfunction

  localparam int MEM_TIMEOUT_DFLT = 16;
  localparam int MEM_WAIT_CNT_W   = wait_cnt_w(MEM_TIMEOUT_DFLT);

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the instruction in ID and the load held in ID/EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  logic rs_hit_s;
  logic rt_hit_s;

  // Register zero is never a real dependency.
  always_comb begin
    rs_hit_s = (ex_rt == id_rs);
    rt_hit_s = id_uses_rt & (ex_rt == id_rt);
    load_use = ex_memread & (ex_rt != REG_ZERO) & (rs_hit_s | rt_hit_s);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: memory hold with timeout, branch flush, load-use stall,
// plus sticky timeout error and saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DFLT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             ex_mem_flush,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = wait_cnt_w(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  ctrl_state_e       state_r, state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_nxt_s;
  logic              mem_err_r, err_set_s;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              load_use_s;
  logic              hold_s;
  logic              abandon_s;

  load_use_detect u_load_use_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use_s)
  );

  // Next-state logic and per-cycle hold/abandon decision.
  always_comb begin
    state_nxt_s = state_r;
    wait_nxt_s  = wait_cnt_r;
    hold_s      = 1'b0;
    abandon_s   = 1'b0;
    err_set_s   = 1'b0;
    case (state_r)
      RUN: begin
        if (mem_access && !dmem_ready) begin
          hold_s      = 1'b1;
          state_nxt_s = MEM_WAIT;
          wait_nxt_s  = WAIT_W'(1);
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt_s = RUN;
          wait_nxt_s  = '0;
        end else if (wait_cnt_r < WAIT_LAST) begin
          hold_s     = 1'b1;
          wait_nxt_s = wait_cnt_r + WAIT_W'(1);
        end else begin
          abandon_s   = 1'b1;
          err_set_s   = 1'b1;
          state_nxt_s = RUN;
          wait_nxt_s  = '0;
        end
      end
      default: begin
        state_nxt_s = RUN;
        wait_nxt_s  = '0;
      end
    endcase
  end

  // Output mux: memory hold beats branch flush beats load-use stall.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = abandon_s;
    if (!rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b0;
    end else if (hold_s) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (mem_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use_s) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  // State, wait counter, sticky error and saturating stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RUN;
      wait_cnt_r  <= '0;
      mem_err_r   <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_nxt_s;
      mem_err_r  <= mem_err_r | err_set_s;
      if (!pc_write && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign mem_err      = mem_err_r;
  assign stall_cycles = stall_cnt_r;

endmodule
